lcd_text_writer: RTL and testbench
==================================

// Module: lcd_text_writer
// PURPOSE
// Parametrised HD44780-style character-LCD writer with 8-bit bus and write-only RW.
// Runs power-up init, then on each start clears the display and writes MSG_LEN chars
// fetched from an external char ROM. Wraps to line 2 (DDRAM 0x40) after LINE_LEN chars.
// Every byte gets real setup/enable/hold timing. Sits between display-message ROMs and LCD pins.
// PARAMETERS
// MSG_LEN        7      chars per message; 1..2*LINE_LEN, excess chars never fetched
// LINE_LEN       16     columns per line
// POWERUP_CYC    20     cycles after reset before first init command
// SETUP_CYC      2      cycles lcd_data/lcd_rs stable with lcd_en=0 before pulse
// EN_CYC         4      cycles lcd_en held high per byte
// CMD_WAIT_CYC   8      cycles lcd_en=0, bus held, after a normal byte
// CLR_WAIT_CYC   32     wait after 0x01 (clear) and 0x02 (home) instead of CMD_WAIT_CYC
// PORTS
// clk        in   1   system clock; all logic on rising edge
// reset      in   1   synchronous, active-high
// start      in   1   request to write one message; sampled only in IDLE
// char_addr  out  AW  ROM address, AW=$clog2(MSG_LEN) min 1
// char_data  in   8   ROM data, valid exactly 1 cycle after char_addr changes
// lcd_data   out  8   LCD data bus
// lcd_rs     out  1   0=command, 1=data
// lcd_rw     out  1   tied 0 (write-only)
// lcd_en     out  1   enable strobe
// busy       out  1   high from POWERUP through end of message
// done       out  1   one-cycle pulse when last byte's wait completes
// BEHAVIOUR
// - Reset values: lcd_data=0, lcd_rs=0, lcd_rw=0, lcd_en=0, busy=1, done=0, char_addr=0.
// - Reset mid-operation aborts immediately (lcd_en forced 0 next edge) and re-enters POWERUP.
// - All outputs are registered; no combinational path from start/char_data to pins.
// - States: POWERUP -> INIT -> IDLE -> CLEAR -> FETCH -> WRITE -> (WRAP) -> DONE -> IDLE.
// - POWERUP: count POWERUP_CYC, then go to INIT.
// - INIT: write commands 0x38, 0x0C, 0x06, 0x01 in order, then go to IDLE.
// - IDLE: busy=0. start=1 goes to CLEAR (0x01 command), col=0, idx=0.
//   start while busy is ignored and is not queued.
// - Byte write: 1 cycle load, then SETUP_CYC with en=0, then EN_CYC with en=1,
//   then WAIT cycles with en=0. Data and RS stay stable for the whole byte.
//   Total = 1 + SETUP_CYC + EN_CYC + WAIT cycles.
// - FETCH: drive char_addr=idx, capture char_data next cycle, then WRITE with rs=1.
// - After each char: idx++ and col++.
//   If idx==MSG_LEN, go to DONE.
//   Else if col==LINE_LEN and line==0, go to WRAP: write command 0xC0 with rs=0, col=0, line=1.
//   Else go to FETCH.
// - On line 2 with col==LINE_LEN, stop (truncate) and go to DONE.
// - MSG_LEN==LINE_LEN: no 0xC0 is issued.
// - DONE: done=1 for exactly one cycle, then IDLE (busy=0 same cycle as entering IDLE).
// - Counters: delay counter width = $clog2(max timing param + 1).
//   It saturates at 0 and never wraps.
// STRUCTURE
// - Shared package lcd_pkg holds:
//   command constants (FUNC_SET_8B2L=8'h38, DISP_ON=8'h0C, ENTRY_INC=8'h06,
//   CLEAR=8'h01, HOME=8'h02, LINE2=8'hC0);
//   the state enum; timing default constants.
// - Sub-module lcd_byte_writer: go/byte/rs in, ready out.
//   Owns the setup/en/wait counter and selects CLR_WAIT_CYC for 0x01/0x02.
// - Top FSM sequences commands/chars only.
// TESTING
// 1. Reset held 3 cycles -> all outputs at reset values; busy=1.
//    First lcd_en rise exactly POWERUP_CYC+1+SETUP_CYC cycles after reset release.
// 2. Init -> bytes 0x38, 0x0C, 0x06, 0x01 with rs=0.
//    Each en-high window == EN_CYC; data stable across setup+en+wait; then busy=0.
// 3. ROM="WASHING", MSG_LEN=7, start pulse -> 0x01, then W, A, S, H, I, N, G with rs=1.
//    No 0xC0 issued; single done pulse; busy falls with done.
// 4. MSG_LEN=20, LINE_LEN=16 -> 0xC0 (rs=0) between char 16 and char 17.
//    20 data bytes total. MSG_LEN=40 -> only 32 chars written, then done.
// 5. start asserted during a write and held high -> no second message queued.
//    A new start in IDLE runs exactly one more message.
// 6. reset asserted while lcd_en=1 mid-message -> lcd_en=0 next cycle, done never pulses.
//    Full init sequence repeats.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the HD44780-style text writer.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] ENTRY_INC     = 8'h06;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] HOME          = 8'h02;
  localparam logic [7:0] LINE2         = 8'hC0;

  localparam int DEF_MSG_LEN      = 7;
  localparam int DEF_LINE_LEN     = 16;
  localparam int DEF_POWERUP_CYC  = 20;
  localparam int DEF_SETUP_CYC    = 2;
  localparam int DEF_EN_CYC       = 4;
  localparam int DEF_CMD_WAIT_CYC = 8;
  localparam int DEF_CLR_WAIT_CYC = 32;

  typedef enum logic [2:0] {
    ST_POWERUP, ST_INIT, ST_IDLE, ST_CLEAR, ST_FETCH, ST_WRITE, ST_WRAP, ST_DONE
  } lcd_state_e;

  typedef enum logic [2:0] {
    PH_IDLE, PH_LOAD, PH_SETUP, PH_EN, PH_WAIT
  } byte_phase_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return FUNC_SET_8B2L;
      2'd1:    return DISP_ON;
      2'd2:    return ENTRY_INC;
      default: return CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Drives one byte onto the LCD bus with load, setup, enable and post-write wait phases.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int EN_CYC       = DEF_EN_CYC,
  parameter int CMD_WAIT_CYC = DEF_CMD_WAIT_CYC,
  parameter int CLR_WAIT_CYC = DEF_CLR_WAIT_CYC,
  parameter int CW           = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go_i,
  input  logic [7:0] byte_i,
  input  logic       rs_i,
  output logic       ready_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_en_o
);

  byte_phase_e   phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          en_q, en_d;
  logic          long_q, long_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      long_q  <= long_d;
    end
  end

  // Each timed phase loads N-1 and advances when the counter has drained to 0.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    data_d  = data_q;
    rs_d    = rs_q;
    en_d    = en_q;
    long_d  = long_q;
    case (phase_q)
      PH_IDLE: begin
        if (go_i) begin
          phase_d = PH_LOAD;
          data_d  = byte_i;
          rs_d    = rs_i;
          long_d  = !rs_i && (byte_i == CLEAR || byte_i == HOME);
        end
      end
      PH_LOAD: begin
        phase_d = PH_SETUP;
        cnt_d   = CW'(SETUP_CYC - 1);
      end
      PH_SETUP: begin
        if (cnt_q == '0) begin
          phase_d = PH_EN;
          en_d    = 1'b1;
          cnt_d   = CW'(EN_CYC - 1);
        end
      end
      PH_EN: begin
        if (cnt_q == '0) begin
          phase_d = PH_WAIT;
          en_d    = 1'b0;
          cnt_d   = long_q ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
        end
      end
      PH_WAIT: begin
        if (cnt_q == '0) phase_d = PH_IDLE;
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  assign ready_o    = (phase_q == PH_IDLE);
  assign lcd_data_o = data_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_en_o   = en_q;

endmodule

// File: rtl/lcd_text_writer.sv
// Sequences power-up init, then clear plus one ROM message per start, wrapping to line 2.
module lcd_text_writer
  import lcd_pkg::*;
#(
  parameter int MSG_LEN      = DEF_MSG_LEN,
  parameter int LINE_LEN     = DEF_LINE_LEN,
  parameter int POWERUP_CYC  = DEF_POWERUP_CYC,
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int EN_CYC       = DEF_EN_CYC,
  parameter int CMD_WAIT_CYC = DEF_CMD_WAIT_CYC,
  parameter int CLR_WAIT_CYC = DEF_CLR_WAIT_CYC,
  localparam int AW          = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] char_addr,
  input  logic [7:0]    char_data,
  output logic [7:0]    lcd_data,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic          lcd_en,
  output logic          busy,
  output logic          done
);

  localparam int MAX_T = max_int(max_int(max_int(POWERUP_CYC, SETUP_CYC),
                                         max_int(EN_CYC, CMD_WAIT_CYC)), CLR_WAIT_CYC);
  localparam int CW    = $clog2(MAX_T + 1);
  localparam int IW    = $clog2(MSG_LEN + 1);
  localparam int LW    = $clog2(LINE_LEN + 1);

  lcd_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d, idx_inc;
  logic [LW-1:0] col_q, col_d, col_inc;
  logic          line_q, line_d;
  logic          sent_q, sent_d;
  logic [1:0]    iidx_q, iidx_d;
  logic          fwait_q, fwait_d;
  logic [7:0]    char_q, char_d;
  logic [AW-1:0] char_addr_q;
  logic          busy_q, done_q;

  logic          wr_go, wr_rs, wr_ready, is_byte_state, byte_done;
  logic [7:0]    wr_byte;

  assign idx_inc = idx_q + 1'b1;
  assign col_inc = col_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_POWERUP;
      cnt_q       <= CW'(POWERUP_CYC - 1);
      idx_q       <= '0;
      col_q       <= '0;
      line_q      <= 1'b0;
      sent_q      <= 1'b0;
      iidx_q      <= '0;
      fwait_q     <= 1'b0;
      char_q      <= '0;
      char_addr_q <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      line_q  <= line_d;
      sent_q  <= sent_d;
      iidx_q  <= iidx_d;
      fwait_q <= fwait_d;
      char_q  <= char_d;
      if (state_d == ST_FETCH && state_q != ST_FETCH) char_addr_q <= idx_d[AW-1:0];
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // sent_q marks that the current state's byte was handed to the writer;
  // the writer returning to ready afterwards means that byte's wait is over.
  always_comb begin
    is_byte_state = (state_q == ST_INIT) || (state_q == ST_CLEAR) ||
                    (state_q == ST_WRITE) || (state_q == ST_WRAP);
    wr_go     = is_byte_state && wr_ready && !sent_q;
    byte_done = is_byte_state && wr_ready && sent_q;

    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    idx_d   = idx_q;
    col_d   = col_q;
    line_d  = line_q;
    sent_d  = wr_go ? 1'b1 : (byte_done ? 1'b0 : sent_q);
    iidx_d  = iidx_q;
    fwait_d = fwait_q;
    char_d  = char_q;
    wr_byte = 8'h00;
    wr_rs   = 1'b0;

    case (state_q)
      ST_POWERUP: begin
        if (cnt_q <= CW'(1)) state_d = ST_INIT;
      end
      ST_INIT: begin
        wr_byte = init_cmd(iidx_q);
        if (byte_done) begin
          if (iidx_q == 2'd3) state_d = ST_IDLE;
          else iidx_d = iidx_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
          col_d   = '0;
          line_d  = 1'b0;
        end
      end
      ST_CLEAR: begin
        wr_byte = CLEAR;
        if (byte_done) begin
          state_d = ST_FETCH;
          fwait_d = 1'b1;
        end
      end
      ST_FETCH: begin
        // One cycle for the ROM to answer the new address, then capture.
        if (fwait_q) fwait_d = 1'b0;
        else begin
          char_d  = char_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_byte = char_q;
        wr_rs   = 1'b1;
        if (byte_done) begin
          idx_d = idx_inc;
          col_d = col_inc;
          if (idx_inc == IW'(MSG_LEN)) state_d = ST_DONE;
          else if (col_inc == LW'(LINE_LEN)) state_d = line_q ? ST_DONE : ST_WRAP;
          else begin
            state_d = ST_FETCH;
            fwait_d = 1'b1;
          end
        end
      end
      ST_WRAP: begin
        wr_byte = LINE2;
        if (byte_done) begin
          col_d   = '0;
          line_d  = 1'b1;
          state_d = ST_FETCH;
          fwait_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_POWERUP;
    endcase
  end

  lcd_byte_writer #(
    .SETUP_CYC   (SETUP_CYC),
    .EN_CYC      (EN_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC),
    .CLR_WAIT_CYC(CLR_WAIT_CYC),
    .CW          (CW)
  ) u_byte (
    .clk       (clk),
    .reset     (reset),
    .go_i      (wr_go),
    .byte_i    (wr_byte),
    .rs_i      (wr_rs),
    .ready_o   (wr_ready),
    .lcd_data_o(lcd_data),
    .lcd_rs_o  (lcd_rs),
    .lcd_en_o  (lcd_en)
  );

  assign char_addr = char_addr_q;
  assign lcd_rw    = 1'b0;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed bench: three writers (7, 20 and 40 char messages) share one clock and reset.
module tb_lcd_text_writer;

  localparam int P = 20, S = 2, E = 4, W = 8, WC = 32;

  logic clk = 1'b0;
  logic reset;
  logic start0, start1, start2;
  logic [2:0] addr0;
  logic [4:0] addr1;
  logic [5:0] addr2;
  logic [7:0] cdata0, cdata1, cdata2;
  logic [7:0] data_v [3];
  logic [2:0] rs_v, rw_v, en_v, busy_v, done_v;
  logic [7:0] rom0 [8];

  always #5 clk = ~clk;

  lcd_text_writer #(.MSG_LEN(7)) u0 (
    .clk(clk), .reset(reset), .start(start0), .char_addr(addr0), .char_data(cdata0),
    .lcd_data(data_v[0]), .lcd_rs(rs_v[0]), .lcd_rw(rw_v[0]), .lcd_en(en_v[0]),
    .busy(busy_v[0]), .done(done_v[0]));
  lcd_text_writer #(.MSG_LEN(20)) u1 (
    .clk(clk), .reset(reset), .start(start1), .char_addr(addr1), .char_data(cdata1),
    .lcd_data(data_v[1]), .lcd_rs(rs_v[1]), .lcd_rw(rw_v[1]), .lcd_en(en_v[1]),
    .busy(busy_v[1]), .done(done_v[1]));
  lcd_text_writer #(.MSG_LEN(40)) u2 (
    .clk(clk), .reset(reset), .start(start2), .char_addr(addr2), .char_data(cdata2),
    .lcd_data(data_v[2]), .lcd_rs(rs_v[2]), .lcd_rw(rw_v[2]), .lcd_en(en_v[2]),
    .busy(busy_v[2]), .done(done_v[2]));

  // Synchronous ROMs: data follows the address one clock later.
  always @(posedge clk) begin
    cdata0 <= rom0[addr0];
    cdata1 <= 8'h41 + {3'b000, addr1};
    cdata2 <= 8'h41 + {2'b00, addr2};
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- bus monitor ----------------
  logic [10:0] log_q [$];
  logic [10:0] exp_q [$];
  int unsigned cyc = 0;
  int unsigned rise_cyc [3], fall_cyc [3], chg_cyc [3];
  int unsigned done_pulses [3], done_hi [3];
  logic [8:0]  rise_bus [3], prev_bus [3];
  logic [2:0]  en_prev, done_prev, have_fall, last_long;
  logic [5:0]  max_addr2 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        en_prev[i]   <= 1'b0;
        done_prev[i] <= 1'b0;
        have_fall[i] <= 1'b0;
        prev_bus[i]  <= {rs_v[i], data_v[i]};
        chg_cyc[i]   <= cyc;
      end else begin
        en_prev[i]   <= en_v[i];
        done_prev[i] <= done_v[i];
        prev_bus[i]  <= {rs_v[i], data_v[i]};
        if ({rs_v[i], data_v[i]} != prev_bus[i]) begin
          chg_cyc[i] <= cyc;
          if (have_fall[i] && !en_v[i])
            check("bus_hold_after_en", 32'((cyc - fall_cyc[i] >= 32'(last_long[i] ? WC : W)) ?
                  (last_long[i] ? WC : W) : (cyc - fall_cyc[i])), 32'(last_long[i] ? WC : W));
        end
        if (en_v[i] && !en_prev[i]) begin
          rise_cyc[i]  <= cyc;
          rise_bus[i]  <= {rs_v[i], data_v[i]};
          last_long[i] <= !rs_v[i] && (data_v[i] == 8'h01 || data_v[i] == 8'h02);
          log_q.push_back({2'(i), rs_v[i], data_v[i]});
          check("setup_time", ({rs_v[i], data_v[i]} != prev_bus[i]) ? 32'(0) :
                ((cyc - chg_cyc[i] >= S + 1) ? 32'(S + 1) : (cyc - chg_cyc[i])), 32'(S + 1));
          if (have_fall[i])
            check("byte_spacing", 32'((cyc - fall_cyc[i] >= 32'((last_long[i] ? WC : W) + 1 + S)) ?
                  ((last_long[i] ? WC : W) + 1 + S) : (cyc - fall_cyc[i])),
                  32'((last_long[i] ? WC : W) + 1 + S));
        end
        if (!en_v[i] && en_prev[i]) begin
          fall_cyc[i]  <= cyc;
          have_fall[i] <= 1'b1;
          check("en_width", cyc - rise_cyc[i], 32'(E));
          check("bus_stable_en", 32'({rs_v[i], data_v[i]}), 32'(rise_bus[i]));
        end
        if (done_v[i] && !done_prev[i]) done_pulses[i] <= done_pulses[i] + 1;
        if (done_v[i]) done_hi[i] <= done_hi[i] + 1;
      end
    end
    if (!reset && addr2 > max_addr2) max_addr2 <= addr2;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input int inst, input logic rs, input logic [7:0] d);
    exp_q.push_back({2'(inst), rs, d});
  endtask

  task automatic exp_init_all();
    logic [7:0] cmds [4];
    cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 3; i++) exp_push(i, 1'b0, cmds[b]);
  endtask

  task automatic exp_washing();
    logic [7:0] msg [7];
    msg = '{8'h57, 8'h41, 8'h53, 8'h48, 8'h49, 8'h4E, 8'h47};
    exp_push(0, 1'b0, 8'h01);
    for (int k = 0; k < 7; k++) exp_push(0, 1'b1, msg[k]);
  endtask

  task automatic compare_log(input string tag);
    logic [10:0] g, e;
    check({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    while (log_q.size() > 0 && exp_q.size() > 0) begin
      g = log_q.pop_front();
      e = exp_q.pop_front();
      check(tag, 32'(g), 32'(e));
    end
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_done(input int i, input int budget, input string tag);
    int ok = 0;
    for (int k = 0; k < budget && ok == 0; k++) begin
      tick();
      if (done_v[i]) ok = 1;
    end
    check(tag, 32'(ok), 32'(1));
  endtask

  task automatic wait_all_idle(input int budget, input string tag);
    int ok = 0;
    for (int k = 0; k < budget && ok == 0; k++) begin
      tick();
      if (busy_v == 3'b000) ok = 1;
    end
    check(tag, 32'(ok), 32'(1));
  endtask

  task automatic pulse_start(input int i);
    if (i == 0) start0 = 1'b1; else if (i == 1) start1 = 1'b1; else start2 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, found, base_p, base_h, busy_cnt;
    rom0 = '{8'h57, 8'h41, 8'h53, 8'h48, 8'h49, 8'h4E, 8'h47, 8'h3F};
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    done_pulses = '{0, 0, 0};
    done_hi = '{0, 0, 0};

    // Reset values and power-up timing
    repeat (3) tick();
    check("rst_lcd_data", 32'(data_v[0]), 32'h0);
    check("rst_lcd_rs", 32'(rs_v[0]), 32'h0);
    check("rst_lcd_rw", 32'(rw_v[0]), 32'h0);
    check("rst_lcd_en", 32'(en_v[0]), 32'h0);
    check("rst_busy", 32'(busy_v), 32'h7);
    check("rst_done", 32'(done_v), 32'h0);
    check("rst_char_addr", 32'(addr0), 32'h0);
    @(negedge clk) reset = 1'b0;
    n = 0; found = 0;
    for (int k = 1; k <= 200 && found == 0; k++) begin
      tick();
      if (en_v[0]) begin found = 1; n = k; end
    end
    check("first_en_rise", 32'(n), 32'(P + 1 + S));

    // Init command stream
    wait_all_idle(1000, "init_idle");
    check("rw_low", 32'(rw_v), 32'h0);
    exp_init_all();
    compare_log("init_bytes");

    // WASHING, single line
    base_p = done_pulses[0]; base_h = done_hi[0];
    pulse_start(0);
    check("busy_after_start", 32'(busy_v[0]), 32'h1);
    wait_done(0, 2000, "msg7_done");
    check("busy_at_done", 32'(busy_v[0]), 32'h1);
    tick();
    check("done_one_cycle", 32'(done_v[0]), 32'h0);
    check("busy_falls_with_done", 32'(busy_v[0]), 32'h0);
    repeat (20) tick();
    check("msg7_done_pulses", 32'(done_pulses[0] - base_p), 32'h1);
    check("msg7_done_width", 32'(done_hi[0] - base_h), 32'h1);
    exp_washing();
    compare_log("msg7_bytes");

    // 20 chars: wrap after 16
    pulse_start(1);
    wait_done(1, 3000, "msg20_done");
    repeat (5) tick();
    exp_push(1, 1'b0, 8'h01);
    for (int k = 0; k < 20; k++) begin
      if (k == 16) exp_push(1, 1'b0, 8'hC0);
      exp_push(1, 1'b1, 8'h41 + 8'(k));
    end
    compare_log("msg20_bytes");

    // 40 chars: truncated at 32
    pulse_start(2);
    wait_done(2, 4000, "msg40_done");
    repeat (5) tick();
    exp_push(2, 1'b0, 8'h01);
    for (int k = 0; k < 32; k++) begin
      if (k == 16) exp_push(2, 1'b0, 8'hC0);
      exp_push(2, 1'b1, 8'h41 + 8'(k));
    end
    compare_log("msg40_bytes");
    check("msg40_max_addr", 32'(max_addr2), 32'd31);

    // start held during a message is not queued
    base_p = done_pulses[0];
    pulse_start(0);
    repeat (40) tick();
    start0 = 1'b1;
    wait_done(0, 2000, "held_start_done");
    start0 = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (busy_v[0]) busy_cnt++;
    end
    check("no_requeue_busy", 32'(busy_cnt), 32'h0);
    exp_washing();
    compare_log("held_start_bytes");
    pulse_start(0);
    wait_done(0, 2000, "restart_done");
    repeat (20) tick();
    check("restart_done_pulses", 32'(done_pulses[0] - base_p), 32'h2);
    exp_washing();
    compare_log("restart_bytes");

    // Reset while lcd_en is high mid-message
    pulse_start(0);
    found = 0;
    for (int k = 0; k < 2000 && found == 0; k++) begin
      tick();
      if (en_v[0] && log_q.size() >= 4) found = 1;
    end
    check("midmsg_en_seen", 32'(found), 32'h1);
    base_p = done_pulses[0];
    reset = 1'b1;
    tick();
    check("abort_en_low", 32'(en_v[0]), 32'h0);
    check("abort_busy", 32'(busy_v[0]), 32'h1);
    tick();
    @(negedge clk) reset = 1'b0;
    log_q.delete();
    exp_q.delete();
    wait_all_idle(1000, "reinit_idle");
    repeat (20) tick();
    check("abort_no_done", 32'(done_pulses[0] - base_p), 32'h0);
    exp_init_all();
    compare_log("reinit_bytes");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
